// File: rtl/enc_pkg.sv
// Shared definitions for the request encoder and its link-side neighbours.
package enc_pkg;

  // Priority mode encodings; 2'b11 falls back to fixed-high.
  localparam logic [1:0] ENC_HIGH = 2'b00;
  localparam logic [1:0] ENC_LOW  = 2'b01;
  localparam logic [1:0] ENC_RR   = 2'b10;

  // Result field offsets above the index field: result = {valid, multi, index}.
  localparam int MULTI_BIT = 0;
  localparam int VALID_BIT = 1;

  // Width of one encoded result for a given number of request lines.
  function automatic int enc_result_w(input int nreq);
    return $clog2(nreq) + 2;
  endfunction

endpackage

// File: rtl/enc_result_fifo2.sv
// Two-entry result FIFO with 1-bit wrapping pointers and a 0..2 occupancy count.
// Head output reads zero when empty and depends on registers only.
module enc_result_fifo2 #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [1:0]    occ
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    occ_q;
  logic          push_ok;
  logic          pop_ok;

  // Guard the strobes locally so a misbehaving caller cannot corrupt the count.
  assign full    = (occ_q == 2'd2);
  assign empty   = (occ_q == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign occ     = occ_q;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage, pointers and occupancy; reset flushes every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Request-vector priority encoder with fixed-high, fixed-low and round-robin
// modes. Results are queued in a 2-entry FIFO behind EN/RDY handshakes.
module prio_encoder_rr
  import enc_pkg::*;
#(
  parameter int NREQ = 8,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            EN_mav_putvalue,
  input  logic [NREQ-1:0] mav_putvalue_req,
  input  logic [1:0]      mav_putvalue_mode,
  output logic            RDY_mav_putvalue,
  input  logic            EN_mv_get,
  output logic [IDXW+1:0] mv_get,
  output logic            RDY_mv_get,
  output logic            mv_scopbusy,
  output logic            RDY_mv_scopbusy
);

  localparam int RW = enc_result_w(NREQ);

  logic [IDXW-1:0] rr_ptr;
  logic [IDXW-1:0] idx_hi;
  logic [IDXW-1:0] idx_lo;
  logic [IDXW-1:0] idx_rr;
  logic [IDXW-1:0] enc_idx;
  logic            enc_valid;
  logic            enc_multi;
  logic            rr_found;
  int              rr_pos;
  logic [RW-1:0]   enc_result;

  logic            put_fire;
  logic            get_fire;
  logic            fifo_full;
  logic            fifo_empty;
  logic [1:0]      fifo_occ;

  // Encode the request vector; all three scans run in parallel and mode selects.
  always_comb begin
    enc_valid = |mav_putvalue_req;
    enc_multi = (mav_putvalue_req & (mav_putvalue_req - 1'b1)) != '0;

    idx_hi = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (mav_putvalue_req[i]) idx_hi = IDXW'(i);
    end

    idx_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (mav_putvalue_req[i]) idx_lo = IDXW'(i);
    end

    // Upward search from rr_ptr with wrap; the first hit wins.
    idx_rr   = '0;
    rr_found = 1'b0;
    rr_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      rr_pos = int'(rr_ptr) + k;
      if (rr_pos >= NREQ) rr_pos = rr_pos - NREQ;
      if (!rr_found && mav_putvalue_req[rr_pos]) begin
        idx_rr   = IDXW'(rr_pos);
        rr_found = 1'b1;
      end
    end

    case (mav_putvalue_mode)
      ENC_HIGH: enc_idx = idx_hi;
      ENC_LOW:  enc_idx = idx_lo;
      ENC_RR:   enc_idx = idx_rr;
      default:  enc_idx = idx_hi;
    endcase

    enc_result                  = '0;
    enc_result[IDXW-1:0]        = enc_idx;
    enc_result[IDXW+MULTI_BIT]  = enc_multi;
    enc_result[IDXW+VALID_BIT]  = enc_valid;
  end

  // Handshakes: no bypass when full, no passthrough when empty.
  assign RDY_mav_putvalue = !fifo_full;
  assign RDY_mv_get       = !fifo_empty;
  assign put_fire         = EN_mav_putvalue && RDY_mav_putvalue;
  assign get_fire         = EN_mv_get && RDY_mv_get;
  assign mv_scopbusy      = (fifo_occ != 2'd0);
  assign RDY_mv_scopbusy  = 1'b1;

  // Round-robin pointer advances past the granted line on accepted RR puts only.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr <= '0;
    end else if (put_fire && (mav_putvalue_mode == ENC_RR) && enc_valid) begin
      rr_ptr <= (enc_idx == IDXW'(NREQ - 1)) ? '0 : enc_idx + 1'b1;
    end
  end

  enc_result_fifo2 #(
    .DW(RW)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (put_fire),
    .pop   (get_fire),
    .din   (enc_result),
    .dout  (mv_get),
    .full  (fifo_full),
    .empty (fifo_empty),
    .occ   (fifo_occ)
  );

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr (NREQ=8) with a result scoreboard.
module tb_prio_encoder_rr;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EN_mav_putvalue;
  logic [7:0] mav_putvalue_req;
  logic [1:0] mav_putvalue_mode;
  logic       RDY_mav_putvalue;
  logic       EN_mv_get;
  logic [4:0] mv_get;
  logic       RDY_mv_get;
  logic       mv_scopbusy;
  logic       RDY_mv_scopbusy;

  int         total = 0;
  int         bad   = 0;
  logic [4:0] sb[$];
  int         m_occ = 0;
  logic [2:0] m_rr  = 3'd0;

  always #5 CLK = ~CLK;

  prio_encoder_rr #(.NREQ(8)) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .EN_mav_putvalue   (EN_mav_putvalue),
    .mav_putvalue_req  (mav_putvalue_req),
    .mav_putvalue_mode (mav_putvalue_mode),
    .RDY_mav_putvalue  (RDY_mav_putvalue),
    .EN_mv_get         (EN_mv_get),
    .mv_get            (mv_get),
    .RDY_mv_get        (RDY_mv_get),
    .mv_scopbusy       (mv_scopbusy),
    .RDY_mv_scopbusy   (RDY_mv_scopbusy)
  );

  function automatic logic [4:0] model(input logic [7:0] r, input logic [1:0] m, input logic [2:0] p);
    int idx;
    int pos;
    idx = 0;
    if (r == 8'h00) return 5'b00000;
    case (m)
      2'b01: for (int i = 7; i >= 0; i--) if (r[i]) idx = i;
      2'b10: for (int k = 7; k >= 0; k--) begin
               pos = (int'(p) + k) % 8;
               if (r[pos]) idx = pos;
             end
      default: for (int i = 0; i < 8; i++) if (r[i]) idx = i;
    endcase
    return {1'b1, ($countones(r) > 1), idx[2:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_rdy_put"}, 32'(RDY_mav_putvalue), 32'(m_occ < 2));
    chk({tag, "_rdy_get"}, 32'(RDY_mv_get), 32'(m_occ > 0));
    chk({tag, "_busy"},    32'(mv_scopbusy), 32'(m_occ != 0));
    chk({tag, "_head"},    32'(mv_get), (m_occ > 0) ? 32'(sb[0]) : 32'd0);
  endtask

  // One clock: check current outputs, drive strobes, advance the model after the edge.
  task automatic cycle(input string tag, input logic ep, input logic [7:0] r,
                       input logic [1:0] m, input logic eg);
    logic       pf;
    logic       gf;
    logic [4:0] res;
    logic [4:0] dropped;
    check_outputs(tag);
    if (ep && m_occ == 2)
      $display("note: %s put while RDY_mav_putvalue=0 (protocol error, expect ignored)", tag);
    EN_mav_putvalue   = ep;
    mav_putvalue_req  = r;
    mav_putvalue_mode = m;
    EN_mv_get         = eg;
    pf  = ep && (m_occ < 2);
    gf  = eg && (m_occ > 0);
    res = model(r, m, m_rr);
    @(posedge CLK);
    #1;
    EN_mav_putvalue = 1'b0;
    EN_mv_get       = 1'b0;
    if (gf) begin
      dropped = sb.pop_front();
      m_occ--;
    end
    if (pf) begin
      sb.push_back(res);
      m_occ++;
      if (m == 2'b10 && r != 8'h00) m_rr = (res[2:0] == 3'd7) ? 3'd0 : res[2:0] + 3'd1;
    end
  endtask

  // Put one vector, check the head against a hand-derived value, then pop it.
  task automatic pg(input string tag, input logic [7:0] r, input logic [1:0] m, input logic [4:0] exp);
    cycle({tag, "_put"}, 1'b1, r, m, 1'b0);
    chk({tag, "_lit"}, 32'(mv_get), 32'(exp));
    cycle({tag, "_get"}, 1'b0, 8'h00, 2'b00, 1'b1);
  endtask

  initial begin
    RST_N             = 1'b0;
    EN_mav_putvalue   = 1'b0;
    mav_putvalue_req  = 8'h00;
    mav_putvalue_mode = 2'b00;
    EN_mv_get         = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // 1: idle after reset
    cycle("t1_idle", 1'b0, 8'h00, 2'b00, 1'b0);
    chk("t1_scop_rdy", 32'(RDY_mv_scopbusy), 32'd1);

    // 2: same vector in each mode
    cycle("t2_put_hi", 1'b1, 8'h4A, 2'b00, 1'b0);
    chk("t2_hi_lit", 32'(mv_get), 32'(5'b11110));
    cycle("t2_put_lo", 1'b1, 8'h4A, 2'b01, 1'b0);
    cycle("t2_get_hi", 1'b0, 8'h00, 2'b00, 1'b1);
    chk("t2_lo_lit", 32'(mv_get), 32'(5'b11001));
    cycle("t2_put_rr_get", 1'b1, 8'h4A, 2'b10, 1'b1);
    chk("t2_rr_lit", 32'(mv_get), 32'(5'b11001));
    cycle("t2_get_rr", 1'b0, 8'h00, 2'b00, 1'b1);
    pg("t2_rr_ptr2", 8'h4A, 2'b10, 5'b11011);

    // 3: round-robin wrap and fixed-mode isolation
    pg("t3_to7", 8'h40, 2'b10, 5'b10110);
    pg("t3_wrap7", 8'h81, 2'b10, 5'b11111);
    pg("t3_wrap0", 8'h81, 2'b10, 5'b11000);
    pg("t3_fixlo", 8'h02, 2'b01, 5'b10001);
    pg("t3_mode11", 8'h0C, 2'b11, 5'b11011);
    pg("t3_rr1", 8'h03, 2'b10, 5'b11001);

    // 4: backpressure
    cycle("t4_p1", 1'b1, 8'h01, 2'b00, 1'b0);
    cycle("t4_p2", 1'b1, 8'h02, 2'b00, 1'b0);
    cycle("t4_p3_full", 1'b1, 8'h04, 2'b00, 1'b0);
    chk("t4_full_rdy", 32'(RDY_mav_putvalue), 32'd0);
    cycle("t4_putget_full", 1'b1, 8'h08, 2'b00, 1'b1);
    chk("t4_head_after", 32'(mv_get), 32'(5'b10001));
    cycle("t4_drain", 1'b0, 8'h00, 2'b00, 1'b1);

    // 5: empty vector and single-bit vector
    pg("t5_zero", 8'h00, 2'b10, 5'b00000);
    pg("t5_bit4", 8'h10, 2'b10, 5'b10100);
    pg("t5_rr5", 8'h21, 2'b10, 5'b11101);

    // 6: asynchronous reset with the FIFO full
    cycle("t6_p1", 1'b1, 8'h01, 2'b00, 1'b0);
    cycle("t6_p2", 1'b1, 8'h02, 2'b00, 1'b0);
    #3;
    RST_N = 1'b0;
    #1;
    chk("t6_rst_rdy_put", 32'(RDY_mav_putvalue), 32'd1);
    chk("t6_rst_rdy_get", 32'(RDY_mv_get), 32'd0);
    chk("t6_rst_head", 32'(mv_get), 32'd0);
    chk("t6_rst_busy", 32'(mv_scopbusy), 32'd0);
    sb.delete();
    m_occ = 0;
    m_rr  = 3'd0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    cycle("t6_after", 1'b0, 8'h00, 2'b00, 1'b0);
    pg("t6_rr_reset", 8'h4A, 2'b10, 5'b11001);
    cycle("t6_end", 1'b0, 8'h00, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
